// File: rtl/jtag_tdr_pkg.sv
// rtl/jtag_tdr_pkg.sv - shared constants and chain-length helper for the JTAG TDR bank
package jtag_tdr_pkg;

    localparam int DEF_DR_WIDTH  = 8;
    localparam int DEF_TDR_COUNT = 4;
    localparam int DEF_SEL_W     = 4;
    localparam int SEL_BYPASS    = 0;

    // Expected shift length of the path chosen by sel: a full chain, or the 1-bit bypass
    function automatic int chain_len(input int sel, input int tdr_count, input int dr_width);
        if (sel != SEL_BYPASS && sel <= tdr_count)
            return dr_width;
        return 1;
    endfunction

endpackage

// File: rtl/jtag_tdr_cell.sv
// rtl/jtag_tdr_cell.sv - one TDR chain: capture/shift register, update register, update strobe
module jtag_tdr_cell #(
    parameter int                  DR_WIDTH = 8,
    parameter logic [DR_WIDTH-1:0] DR_RESET = '0
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_sel,
    input  logic                i_tdi,
    input  logic                i_capture,
    input  logic                i_shift,
    input  logic                i_update,
    input  logic [DR_WIDTH-1:0] i_dr_in,
    output logic                o_msb,
    output logic [DR_WIDTH-1:0] o_dr_out,
    output logic                o_strobe
);

    logic [DR_WIDTH-1:0] r_shift;
    logic [DR_WIDTH-1:0] r_dr_out;
    logic                r_strobe;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shift  <= '0;
            r_dr_out <= DR_RESET;
            r_strobe <= 1'b0;
        end else begin
            r_strobe <= 1'b0;
            if (i_sel) begin
                if (i_capture)
                    r_shift <= i_dr_in;
                else if (i_shift)
                    r_shift <= {r_shift[DR_WIDTH-2:0], i_tdi};
                else if (i_update) begin
                    r_dr_out <= r_shift;
                    r_strobe <= 1'b1;
                end
            end
        end
    end

    assign o_msb    = r_shift[DR_WIDTH-1];
    assign o_dr_out = r_dr_out;
    assign o_strobe = r_strobe;

endmodule

// File: rtl/jtag_tdr_bank.sv
// rtl/jtag_tdr_bank.sv - bank of JTAG test data registers with bypass; TDR_SHIFT_CHECK_EN adds shift-length checking
module jtag_tdr_bank
    import jtag_tdr_pkg::*;
#(
    parameter int                  DR_WIDTH  = DEF_DR_WIDTH,
    parameter int                  TDR_COUNT = DEF_TDR_COUNT,
    parameter int                  SEL_W     = DEF_SEL_W,
    parameter logic [DR_WIDTH-1:0] DR_RESET  = '0
) (
    input  logic                          TCK,
    input  logic                          TRST_n,
    input  logic                          TDI,
    input  logic                          tdr_select,
    input  logic [SEL_W-1:0]              ir_sel,
    input  logic                          Capture_DR,
    input  logic                          Shift_DR,
    input  logic                          Update_DR,
    input  logic [TDR_COUNT*DR_WIDTH-1:0] DR_in,
    output logic [TDR_COUNT*DR_WIDTH-1:0] DR_out,
    output logic [TDR_COUNT-1:0]          update_strobe,
    output logic                          TDO,
    output logic                          shift_len_err
);

    logic [TDR_COUNT-1:0] w_chain_hit;
    logic [TDR_COUNT-1:0] w_msb;
    logic                 w_upd_ok;
    logic                 w_tdo_src;
    logic                 r_bypass;
    logic                 r_tdo;

    genvar g;
    generate
        for (g = 0; g < TDR_COUNT; g++) begin : g_chain
            assign w_chain_hit[g] = (ir_sel == SEL_W'(g + 1));

            jtag_tdr_cell #(
                .DR_WIDTH (DR_WIDTH),
                .DR_RESET (DR_RESET)
            ) u_cell (
                .i_clk     (TCK),
                .i_rst_n   (TRST_n),
                .i_sel     (tdr_select & w_chain_hit[g]),
                .i_tdi     (TDI),
                .i_capture (Capture_DR),
                .i_shift   (Shift_DR),
                .i_update  (Update_DR & w_upd_ok),
                .i_dr_in   (DR_in[g*DR_WIDTH +: DR_WIDTH]),
                .o_msb     (w_msb[g]),
                .o_dr_out  (DR_out[g*DR_WIDTH +: DR_WIDTH]),
                .o_strobe  (update_strobe[g])
            );
        end
    endgenerate

    // Unmapped ir_sel codes fall through to bypass, same as code 0
    always_ff @(posedge TCK or negedge TRST_n) begin
        if (!TRST_n)
            r_bypass <= 1'b0;
        else if (tdr_select && !(|w_chain_hit)) begin
            if (Capture_DR)
                r_bypass <= 1'b0;
            else if (Shift_DR)
                r_bypass <= TDI;
        end
    end

    always_comb begin
        w_tdo_src = r_bypass;
        for (int k = 0; k < TDR_COUNT; k++)
            if (w_chain_hit[k])
                w_tdo_src = w_msb[k];
    end

    always_ff @(negedge TCK or negedge TRST_n) begin
        if (!TRST_n)
            r_tdo <= 1'b0;
        else if (tdr_select)
            r_tdo <= w_tdo_src;
    end

    assign TDO = r_tdo;

`ifdef TDR_SHIFT_CHECK_EN
    localparam int CNT_MAX = 2 * DR_WIDTH;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    logic [CNT_W-1:0] r_shift_cnt;
    logic             r_len_err;

    assign w_upd_ok = (int'(r_shift_cnt) == chain_len(int'(ir_sel), TDR_COUNT, DR_WIDTH));

    always_ff @(posedge TCK or negedge TRST_n) begin
        if (!TRST_n) begin
            r_shift_cnt <= '0;
            r_len_err   <= 1'b0;
        end else if (tdr_select) begin
            if (Capture_DR) begin
                r_shift_cnt <= '0;
                r_len_err   <= 1'b0;
            end else if (Shift_DR) begin
                if (r_shift_cnt != CNT_W'(CNT_MAX))
                    r_shift_cnt <= r_shift_cnt + 1'b1;
            end else if (Update_DR && !w_upd_ok)
                r_len_err <= 1'b1;
        end
    end

    assign shift_len_err = r_len_err;
`else
    assign w_upd_ok      = 1'b1;
    assign shift_len_err = 1'b0;
`endif

endmodule

// File: tb/tb_jtag_tdr_bank.sv
// tb/tb_jtag_tdr_bank.sv - scoreboard bench for jtag_tdr_bank (DR_WIDTH=8, TDR_COUNT=4)
module tb_jtag_tdr_bank;

    logic        TCK = 1'b0;
    logic        TRST_n;
    logic        TDI;
    logic        tdr_select;
    logic [3:0]  ir_sel;
    logic        Capture_DR, Shift_DR, Update_DR;
    logic [31:0] DR_in;
    logic [31:0] DR_out;
    logic [3:0]  update_strobe;
    logic        TDO;
    logic        shift_len_err;

    int vectors     = 0;
    int miscompares = 0;

    logic        tdo_q[$];
    logic [35:0] strobe_q[$];

    jtag_tdr_bank dut (
        .TCK           (TCK),
        .TRST_n        (TRST_n),
        .TDI           (TDI),
        .tdr_select    (tdr_select),
        .ir_sel        (ir_sel),
        .Capture_DR    (Capture_DR),
        .Shift_DR      (Shift_DR),
        .Update_DR     (Update_DR),
        .DR_in         (DR_in),
        .DR_out        (DR_out),
        .update_strobe (update_strobe),
        .TDO           (TDO),
        .shift_len_err (shift_len_err)
    );

    always #5 TCK = ~TCK;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // TDO is only written on negedge, so it is stable at the shifting posedge
    always @(posedge TCK) begin
        if (TRST_n && tdr_select && Shift_DR && !Capture_DR) begin
            if (tdo_q.size() == 0)
                chk("tdo_unexpected_shift", 64'(TDO), 64'hx);
            else
                chk("tdo_bit", 64'(TDO), 64'(tdo_q.pop_front()));
        end
    end

    always @(negedge TCK) begin
        if (update_strobe != 4'b0) begin
            if (strobe_q.size() == 0)
                chk("strobe_unexpected", {28'h0, update_strobe, DR_out}, 64'h0);
            else
                chk("strobe_dr_out", {28'h0, update_strobe, DR_out}, {28'h0, strobe_q.pop_front()});
        end
    end

    task automatic step(input logic cap, input logic sh, input logic up, input logic tdi);
        @(negedge TCK);
        #1;
        Capture_DR = cap;
        Shift_DR   = sh;
        Update_DR  = up;
        TDI        = tdi;
        @(posedge TCK);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge TCK);
        #1;
    endtask

    task automatic shift_bits(input int n, input logic [15:0] tdi, input logic [15:0] exp);
        for (int i = n - 1; i >= 0; i--) begin
            tdo_q.push_back(exp[i]);
            step(1'b0, 1'b1, 1'b0, tdi[i]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        TRST_n = 1'b0; TDI = 1'b0; tdr_select = 1'b0; ir_sel = 4'd0;
        Capture_DR = 1'b0; Shift_DR = 1'b0; Update_DR = 1'b0;
        DR_in = 32'h44_33_A5_11;
        #12;
        chk("rst_dr_out", 64'(DR_out), 64'h0);
        chk("rst_strobe", 64'(update_strobe), 64'h0);
        chk("rst_tdo", 64'(TDO), 64'h0);
        chk("rst_err", 64'(shift_len_err), 64'h0);
        @(negedge TCK); #1;
        TRST_n = 1'b1;

        // Chain 1 via ir_sel=2: capture A5, shift in 3C
        tdr_select = 1'b1; ir_sel = 4'd2;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        shift_bits(8, 16'h3C, 16'hA5);
        strobe_q.push_back({4'b0010, 32'h0000_3C00});
        step(1'b0, 1'b0, 1'b1, 1'b0);
        idle();
        chk("upd1_dr_out", 64'(DR_out), 64'h0000_3C00);
        chk("upd1_strobe_clear", 64'(update_strobe), 64'h0);

        // Bypass via ir_sel=0
        ir_sel = 4'd0;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        shift_bits(3, 16'b110, 16'b011);
        idle();
        chk("bypass0_dr_out", 64'(DR_out), 64'h0000_3C00);

        // Capture and update together: capture wins
        ir_sel = 4'd2; DR_in[15:8] = 8'h5A;
        step(1'b1, 1'b0, 1'b1, 1'b0);
        idle();
        chk("capupd_dr_out", 64'(DR_out), 64'h0000_3C00);
        chk("capupd_strobe", 64'(update_strobe), 64'h0);
        shift_bits(8, 16'hFF, 16'h5A);
        strobe_q.push_back({4'b0010, 32'h0000_FF00});
        step(1'b0, 1'b0, 1'b1, 1'b0);
        idle();

        // Unmapped ir_sel acts as bypass
        ir_sel = 4'd7;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        shift_bits(3, 16'b100, 16'b010);
        idle();
        chk("bypass7_dr_out", 64'(DR_out), 64'h0000_FF00);

        // Asynchronous reset mid-shift on chain 2
        ir_sel = 4'd3;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        shift_bits(3, 16'b000, 16'b001);
        @(negedge TCK); #1;
        chk("pre_rst_tdo", 64'(TDO), 64'h1);
        TRST_n = 1'b0;
        #1;
        chk("midrst_dr_out", 64'(DR_out), 64'h0);
        chk("midrst_tdo", 64'(TDO), 64'h0);
        chk("midrst_strobe", 64'(update_strobe), 64'h0);
        Shift_DR = 1'b0;
        @(negedge TCK); #1;
        TRST_n = 1'b1;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        shift_bits(8, 16'hC3, 16'h33);
        strobe_q.push_back({4'b0100, 32'h00C3_0000});
        step(1'b0, 1'b0, 1'b1, 1'b0);
        idle();
        chk("post_rst_dr_out", 64'(DR_out), 64'h00C3_0000);

        // Short shift (7 bits) on chain 0 then update
        ir_sel = 4'd1;
        step(1'b1, 1'b0, 1'b0, 1'b0);
        shift_bits(7, 16'h7F, 16'h08);
`ifdef TDR_SHIFT_CHECK_EN
        step(1'b0, 1'b0, 1'b1, 1'b0);
        idle();
        chk("short_dr_out", 64'(DR_out), 64'h00C3_0000);
        chk("short_err", 64'(shift_len_err), 64'h1);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        idle();
        chk("short_err_cleared", 64'(shift_len_err), 64'h0);
`else
        strobe_q.push_back({4'b0001, 32'h00C3_00FF});
        step(1'b0, 1'b0, 1'b1, 1'b0);
        idle();
        chk("short_dr_out", 64'(DR_out), 64'h00C3_00FF);
        chk("short_err", 64'(shift_len_err), 64'h0);
`endif

        idle();
        chk("tdo_q_drained", 64'(tdo_q.size()), 64'h0);
        chk("strobe_q_drained", 64'(strobe_q.size()), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/jtag_tdr_bank.md
JTAG_TDR_BANK -- requirements
Module: jtag_tdr_bank

Interface
REQ-001 SHALL have parameter DR_WIDTH, default 8, bit length of every test data register (TDR) chain (legal range >= 2).
REQ-002 SHALL have parameter TDR_COUNT, default 4, number of TDR chains (legal range 1..15).
REQ-003 SHALL have parameter SEL_W, default 4, width of ir_sel.
REQ-004 SHALL have parameter DR_RESET, default all-zeros, reset value of every DR_out slice.
REQ-005 SHALL have port TCK input, 1 bit, sole clock; one clock, with the TDO stage on its falling edge.
REQ-006 SHALL have port TRST_n input, 1 bit, reset, asynchronous, active-low.
REQ-007 SHALL have port TDI input, 1 bit, serial data in.
REQ-008 SHALL have port tdr_select input, 1 bit, DR path enable; when low, all chains hold.
REQ-009 SHALL have port ir_sel input, SEL_W bits: 0 selects bypass; k in 1..TDR_COUNT selects chain k-1; any other value selects bypass.
REQ-010 SHALL have ports Capture_DR, Shift_DR, Update_DR as inputs, 1 bit each, TAP controller phase levels.
REQ-011 SHALL have port DR_in input, TDR_COUNT*DR_WIDTH bits, parallel capture data; chain k is slice k.
REQ-012 SHALL have port DR_out output, TDR_COUNT*DR_WIDTH bits, registered update data per chain.
REQ-013 SHALL have port update_strobe output, TDR_COUNT bits, one-cycle pulse per chain on update.
REQ-014 SHALL have port TDO output, 1 bit, serial data out.
REQ-015 SHALL have port shift_len_err output, 1 bit, sticky shift-length error (see Configuration).

Function
REQ-016 SHALL act, on posedge TCK with tdr_select=1, on the selected chain only; priority Capture_DR > Shift_DR > Update_DR when several are high.
REQ-017 SHALL, on capture, load shift reg of selected chain from its DR_in slice; bypass bit captures 0.
REQ-018 SHALL, on shift, do shift_reg <= {shift_reg[DR_WIDTH-2:0], TDI}; bypass bit <= TDI.
REQ-019 SHALL, on update, load DR_out slice of selected chain from its shift reg; in the same edge, set update_strobe[k]=1 for exactly one cycle; bypass updates nothing.
REQ-020 SHALL leave non-selected chains' shift regs, DR_out and strobes unchanged; a change of ir_sel mid-shift redirects subsequent shifts to the newly selected chain.
REQ-021 SHALL register TDO on negedge TCK from the selected chain MSB (or bypass bit); it is valid half a cycle after the shifting posedge and holds when tdr_select=0.

Reset
REQ-022 SHALL, while TRST_n=0, asynchronously force: all shift regs and bypass bit 0, DR_out=DR_RESET, update_strobe=0, TDO=0, shift_len_err=0, shift counter 0.
REQ-023 SHALL discard the shift in progress on reset mid-shift; the first posedge after deassertion is processed normally.

Configuration
REQ-024 SHALL, with macro TDR_SHIFT_CHECK_EN defined, count Shift_DR cycles since the last capture (saturating at 2*DR_WIDTH) and, on update where the count != chain length (DR_WIDTH, or 1 for bypass), suppress the DR_out load and strobe and set shift_len_err sticky until the next capture or reset.
REQ-025 SHALL, without TDR_SHIFT_CHECK_EN, perform update unconditionally, omit the counter, and tie shift_len_err to 0 (port retained).

Structure
REQ-026 SHALL place in package jtag_tdr_pkg: SEL_BYPASS constant, default DR_WIDTH/TDR_COUNT/SEL_W, and a chain-length function.
REQ-027 SHALL implement one chain (shift reg, update reg, strobe) as sub-module jtag_tdr_cell, instantiated TDR_COUNT times; select, bypass, TDO and check logic stay in the top.

Verification (DR_WIDTH=8, TDR_COUNT=4)
REQ-028 SHALL cover: TRST_n low mid-shift -> DR_out=0, TDO=0, strobes=0 immediately, without waiting for a TCK edge.
REQ-029 SHALL cover: ir_sel=2, DR_in[1]=0xA5, capture, then 8 shifts of TDI=0x3C MSB-first -> TDO 1,0,1,0,0,1,0,1; then update -> DR_out[1]=0x3C, update_strobe=4'b0010 for one cycle, other slices unchanged.
REQ-030 SHALL cover: ir_sel=0, capture, then shift TDI 1,1,0 -> TDO 0,1,1; DR_out unchanged.
REQ-031 SHALL cover: Capture_DR and Update_DR high in the same cycle -> capture only, no strobe; ir_sel=7 -> bypass behaviour.
REQ-032 SHALL cover, with TDR_SHIFT_CHECK_EN: 7 shifts then update -> DR_out unchanged, no strobe, shift_len_err=1; next capture -> shift_len_err=0.
